// File: rtl/npu_pkg.sv
// npu_pkg: shared definitions for the NPU convolution datapath.
//   - state_t      : controller FSM encoding (IDLE / MAC / DONE)
//   - kk()         : tap count of a square kernel
//   - prod_width() : width of signed weight x zero-extended unsigned pixel
//   - KK           : tap count for the default 3x3 kernel
package npu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int kk(input int k);
      return k * k;
   endfunction

   // The pixel gains a zero MSB so it can enter a signed multiply.
   function automatic int prod_width(input int weight_w, input int pixel_w);
      return weight_w + pixel_w + 1;
   endfunction

   localparam int KERNEL_SIZE_DEFAULT = 3;
   localparam int KK                  = kk(KERNEL_SIZE_DEFAULT);

endpackage

// File: rtl/npu_mac_unit.sv
// npu_mac_unit: one multiply-accumulate lane.
//   Multiplies a signed weight by an unsigned pixel, sign-extends the
//   product to the accumulator width and accumulates it.
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (clears acc)
//   i_clear        clear accumulator (takes priority over i_en)
//   i_en           accumulate o_sum into the accumulator
//   i_weight       signed weight
//   i_pixel        unsigned pixel
//   o_sum          acc + current product (combinational)
module npu_mac_unit
   import npu_pkg::*;
#(
   parameter int WEIGHT_WIDTH = 8,
   parameter int PIXEL_WIDTH  = 8,
   parameter int ACC_WIDTH    = 21
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_clear,
   input  logic                           i_en,
   input  logic signed [WEIGHT_WIDTH-1:0] i_weight,
   input  logic        [PIXEL_WIDTH-1:0]  i_pixel,
   output logic signed [ACC_WIDTH-1:0]    o_sum
);

   localparam int PROD_W = prod_width(WEIGHT_WIDTH, PIXEL_WIDTH);

   // Sum wraps modulo 2^ACC_WIDTH; no saturation is applied.
   function automatic logic signed [ACC_WIDTH-1:0] sext_prod(
      input logic signed [PROD_W-1:0] p
   );
      return {{(ACC_WIDTH-PROD_W){p[PROD_W-1]}}, p};
   endfunction

   logic signed [PIXEL_WIDTH:0]    pixel_s;
   logic signed [PROD_W-1:0]       prod;
   logic signed [ACC_WIDTH-1:0]    acc_p1;

   assign pixel_s = {1'b0, i_pixel};
   assign prod    = i_weight * pixel_s;
   assign o_sum   = acc_p1 + sext_prod(prod);

   // Stage p1: accumulator register
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         acc_p1 <= '0;
      end else if (i_en) begin
         acc_p1 <= o_sum;
      end
   end

endmodule

// File: rtl/conv_window_mac.sv
// conv_window_mac: dot product of one latched KxK pixel window with the
// weights streamed from the kernel register file, one tap per cycle.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_start       start request (sampled in IDLE, or in DONE with i_ready)
//   i_window      flattened window, pixel i at [i*PIXEL_WIDTH +: PIXEL_WIDTH]
//   o_busy        high whenever the FSM is not IDLE
//   o_rd_addr     kernel register-file read address (registered source)
//   i_rd_data     weight at o_rd_addr, valid in the same cycle
//   o_result      signed dot product, held while o_valid is high
//   o_valid       result valid, cleared when i_ready is sampled high
//   i_ready       downstream accepts the result
module conv_window_mac
   import npu_pkg::*;
#(
   parameter int KERNEL_SIZE       = 3,
   parameter int KERNEL_ADDR_WIDTH = 5,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int PIXEL_WIDTH       = 8,
   parameter int ACC_WIDTH         = 21
) (
   input  logic                                          i_clk,
   input  logic                                          i_rst,
   input  logic                                          i_start,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*PIXEL_WIDTH-1:0] i_window,
   output logic                                          o_busy,
   output logic [KERNEL_ADDR_WIDTH-1:0]                  o_rd_addr,
   input  logic [WEIGHT_WIDTH-1:0]                       i_rd_data,
   output logic [ACC_WIDTH-1:0]                          o_result,
   output logic                                          o_valid,
   input  logic                                          i_ready
);

   localparam int N_TAPS = kk(KERNEL_SIZE);
   localparam int WIN_W  = N_TAPS * PIXEL_WIDTH;

   state_t                          state;
   state_t                          state_nxt;
   logic                            load;
   logic                            mac_en;
   logic                            last;
   logic [KERNEL_ADDR_WIDTH-1:0]    idx_p0;
   logic [WIN_W-1:0]                window_p0;
   logic [PIXEL_WIDTH-1:0]          pixel;
   logic signed [ACC_WIDTH-1:0]     sum;
   logic signed [ACC_WIDTH-1:0]     result_p2;
   logic                            vld_p2;

   assign last      = (idx_p0 == KERNEL_ADDR_WIDTH'(N_TAPS - 1));
   assign pixel     = window_p0[int'(idx_p0) * PIXEL_WIDTH +: PIXEL_WIDTH];
   assign o_busy    = (state != IDLE);
   assign o_rd_addr = (state == MAC) ? idx_p0 : '0;
   assign o_result  = result_p2;
   assign o_valid   = vld_p2;

   // A new window is accepted from IDLE, or straight out of DONE when the
   // result is consumed in the same cycle (back-to-back, no IDLE bubble).
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      mac_en    = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               load      = 1'b1;
               state_nxt = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (i_ready) begin
               if (i_start) begin
                  load      = 1'b1;
                  state_nxt = MAC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stage p0: tap index and latched window
   always_ff @(posedge i_clk) begin
      if (i_rst || load) begin
         idx_p0 <= '0;
      end else if (mac_en) begin
         idx_p0 <= idx_p0 + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (load) begin
         window_p0 <= i_window;
      end
   end

   npu_mac_unit #(
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .PIXEL_WIDTH  (PIXEL_WIDTH),
      .ACC_WIDTH    (ACC_WIDTH)
   ) u_mac (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (load),
      .i_en     (mac_en),
      .i_weight ($signed(i_rd_data)),
      .i_pixel  (pixel),
      .o_sum    (sum)
   );

   // Stage p2: result register; the final tap's product is folded in here
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         result_p2 <= '0;
         vld_p2    <= 1'b0;
      end else if (mac_en && last) begin
         result_p2 <= sum;
         vld_p2    <= 1'b1;
      end else if (state == DONE && i_ready) begin
         vld_p2    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_window_mac.sv
module tb_conv_window_mac;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [71:0] i_window;
   logic        o_busy;
   logic [4:0]  o_rd_addr;
   logic [7:0]  i_rd_data;
   logic [20:0] o_result;
   logic        o_valid;
   logic        i_ready;

   logic signed [7:0] wts [0:31];

   int tests = 0;
   int fails = 0;

   always #5 i_clk = ~i_clk;

   // Kernel register file model: combinational read.
   assign i_rd_data = wts[o_rd_addr];

   conv_window_mac dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_start   (i_start),
      .i_window  (i_window),
      .o_busy    (o_busy),
      .o_rd_addr (o_rd_addr),
      .i_rd_data (i_rd_data),
      .o_result  (o_result),
      .o_valid   (o_valid),
      .i_ready   (i_ready)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] fill(input logic [7:0] v);
      logic [71:0] w;
      for (int i = 0; i < 9; i++) w[i*8 +: 8] = v;
      return w;
   endfunction

   function automatic logic [71:0] rand_win();
      logic [71:0] w;
      for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
      return w;
   endfunction

   task automatic set_wts(input logic signed [7:0] v);
      for (int i = 0; i < 32; i++) wts[i] = (i < 9) ? v : 8'sd0;
   endtask

   // Reference: plain integer dot product of weights and pixels.
   function automatic longint dot(input logic [71:0] win);
      longint s = 0;
      for (int i = 0; i < 9; i++)
         s += longint'(wts[i]) * longint'({1'b0, win[i*8 +: 8]});
      return s;
   endfunction

   function automatic longint res();
      return longint'($signed(o_result));
   endfunction

   // Called #1 after the start edge. Counts cycles until o_valid.
   task automatic wait_result(input string tag, input longint exp,
                              input int pulse_at, input bit zero_win,
                              input bit chk_addr);
      int n;
      for (n = 1; n <= 20; n++) begin
         if (chk_addr) check({tag, "_addr"}, o_rd_addr, n - 1);
         if (n == 1 && zero_win) i_window = '0;
         if (n == pulse_at) begin
            i_start  = 1'b1;
            i_window = fill(8'd100);
         end
         @(posedge i_clk);
         #1;
         i_start = 1'b0;
         if (o_valid) break;
      end
      check({tag, "_latency"}, n, 9);
      check({tag, "_result"}, res(), exp);
   endtask

   task automatic run(input string tag, input logic [71:0] win, input longint exp,
                      input int pulse_at, input bit zero_win, input bit chk_addr);
      @(negedge i_clk);
      i_window = win;
      i_start  = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      wait_result(tag, exp, pulse_at, zero_win, chk_addr);
   endtask

   task automatic accept(input string tag);
      @(negedge i_clk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      check({tag, "_valid_clr"}, o_valid, 0);
      check({tag, "_idle"}, o_busy, 0);
   endtask

   initial begin
      logic [71:0] w;
      longint      e;
      logic [20:0] held;

      i_rst    = 1'b1;
      i_start  = 1'b0;
      i_ready  = 1'b0;
      i_window = '0;
      set_wts(8'sd0);
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check("rst_busy", o_busy, 0);
      check("rst_valid", o_valid, 0);
      check("rst_result", o_result, 0);
      check("rst_addr", o_rd_addr, 0);
      i_rst = 1'b0;

      // Unit weights and pixels: latency, address walk, sum of nine ones.
      set_wts(8'sd1);
      run("ones", fill(8'd1), 9, 0, 0, 1);
      accept("ones");

      // Extremes of the signed x unsigned product.
      set_wts(-8'sd128);
      run("neg_max", fill(8'd255), -293760, 0, 0, 0);
      accept("neg_max");
      set_wts(8'sd127);
      run("pos_max", fill(8'd255), 291465, 0, 0, 0);
      accept("pos_max");

      // Signed ramp cancels to zero; start pulse mid-MAC must be ignored.
      for (int i = 0; i < 9; i++) wts[i] = 8'(i - 4);
      run("ramp", fill(8'd10), 0, 4, 0, 0);
      held = o_result;
      @(negedge i_clk);
      i_start = 1'b1;
      repeat (5) begin
         @(posedge i_clk);
         #1;
         check("hold_valid", o_valid, 1);
         check("hold_result", o_result, held);
      end
      @(negedge i_clk);
      i_start = 1'b0;
      accept("ramp");

      // Back-to-back: consume result and start the next window together.
      set_wts(8'sd1);
      run("b2b_first", fill(8'd3), 27, 0, 0, 0);
      set_wts(8'sd3);
      @(negedge i_clk);
      i_ready  = 1'b1;
      i_start  = 1'b1;
      i_window = fill(8'd2);
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      i_start = 1'b0;
      check("b2b_no_idle", o_busy, 1);
      check("b2b_valid_clr", o_valid, 0);
      wait_result("b2b", 54, 0, 0, 1);
      accept("b2b");

      // Reset mid-MAC aborts; then a fresh computation.
      set_wts(8'sd1);
      @(negedge i_clk);
      i_window = fill(8'd1);
      i_start  = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (4) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      check("abort_busy", o_busy, 0);
      check("abort_valid", o_valid, 0);
      check("abort_result", o_result, 0);
      check("abort_addr", o_rd_addr, 0);
      run("after_abort", fill(8'd1), 9, 0, 0, 0);
      accept("after_abort");

      // Window changed after the start edge must not matter.
      run("win_change", fill(8'd1), 9, 0, 1, 0);
      accept("win_change");

      // Randomized windows and weights against the reference.
      for (int t = 0; t < 12; t++) begin
         for (int i = 0; i < 9; i++) wts[i] = 8'($urandom_range(0, 255));
         w = rand_win();
         e = dot(w);
         run("random", w, e, 0, 0, 0);
         accept("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed hang expected completion");
      $fatal(1, "timeout");
   end

endmodule
